spi_cfg_master: RTL and testbench

//  SPI master that programs the synth's SPI configuration slave from a parallel

---
 rtl/spi_cfg_master_if.sv | 27 ++
 rtl/spi_cfg_master.sv | 139 +++++++++++++
 tb/tb_spi_cfg_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_master_if.sv
// spi_cfg_master_if: request, config-register and SPI pin bundle for spi_cfg_master.
interface spi_cfg_master_if;
    logic        start_i;
    logic        trig_req_i;
    logic [7:0]  adsr_ai_i;
    logic [7:0]  adsr_di_i;
    logic [7:0]  adsr_s_i;
    logic [7:0]  adsr_ri_i;
    logic [11:0] osc_count_i;
    logic [7:0]  filter_a_i;
    logic [7:0]  filter_b_i;
    logic        busy_o;
    logic        done_o;
    logic        spi_clk_o;
    logic        spi_mosi_o;
    logic        spi_nss_o;
    modport master (
        output start_i, trig_req_i, adsr_ai_i, adsr_di_i, adsr_s_i, adsr_ri_i,
               osc_count_i, filter_a_i, filter_b_i,
        input  busy_o, done_o, spi_clk_o, spi_mosi_o, spi_nss_o
    );
    modport slave (
        input  start_i, trig_req_i, adsr_ai_i, adsr_di_i, adsr_s_i, adsr_ri_i,
               osc_count_i, filter_a_i, filter_b_i,
        output busy_o, done_o, spi_clk_o, spi_mosi_o, spi_nss_o
    );
endinterface

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: uploads the synth config set and trigger commands as 16-bit {addr,data} SPI mode-0 frames.
// Define SPI_AUTO_TRIG_EN to append a trigger frame (0x0801) to every config upload.
module spi_cfg_master #(
    parameter int CLK_DIV = 4
) (
    input logic             clk,
    input logic             rstn,
    spi_cfg_master_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
`ifdef SPI_AUTO_TRIG_EN
    localparam logic AUTO_TRIG = 1'b1;
`else
    localparam logic AUTO_TRIG = 1'b0;
`endif
    localparam logic [3:0] TRIG_FRM = 4'd8;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  bit_q;
    logic [3:0]  frm_q;
    logic [15:0] sr_q;
    logic [7:0]  ai_q, di_q, s_q, ri_q, fa_q, fb_q;
    logic [11:0] osc_q;
    logic        pend_q, busy_q, done_q, sclk_q, mosi_q, nss_q;
    logic        pend_d;
    logic        tick, more, consume;
    logic [3:0]  nxt_frm;
    logic [7:0]  nxt_data;
    logic [15:0] ld_word;
    // frm_q doubles as the frame address: 0..7 config registers, 8 trigger
    always_comb begin
        tick     = cnt_q == 8'(CLK_DIV - 1);
        nxt_frm  = frm_q < 4'd7 ? frm_q + 4'd1 : TRIG_FRM;
        more     = frm_q < 4'd7 || (frm_q == 4'd7 && (AUTO_TRIG || pend_q)) || (frm_q == TRIG_FRM && pend_q);
        nxt_data = nxt_frm == 4'd1 ? di_q :
                   nxt_frm == 4'd2 ? s_q :
                   nxt_frm == 4'd3 ? ri_q :
                   nxt_frm == 4'd4 ? osc_q[7:0] :
                   nxt_frm == 4'd5 ? {4'h0, osc_q[11:8]} :
                   nxt_frm == 4'd6 ? fa_q :
                   nxt_frm == 4'd7 ? fb_q : 8'h01;
        ld_word  = state_q == IDLE ? (bus.start_i ? {8'h00, bus.adsr_ai_i} : {4'h0, TRIG_FRM, 8'h01})
                                   : {4'h0, nxt_frm, nxt_data};
        consume  = state_q == GAP && tick && bit_q[0] && more && nxt_frm == TRIG_FRM;
        pend_d   = state_q == IDLE ? bus.start_i && (pend_q || bus.trig_req_i)
                                   : (pend_q && !consume) || bus.trig_req_i;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frm_q   <= '0;
            sr_q    <= '0;
            ai_q    <= '0;
            di_q    <= '0;
            s_q     <= '0;
            ri_q    <= '0;
            osc_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            nss_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            pend_q <= pend_d;
            cnt_q  <= state_q == IDLE || tick ? '0 : cnt_q + 8'd1;
            case (state_q)
                IDLE: if (bus.start_i || bus.trig_req_i || pend_q) begin
                    state_q <= LEAD;
                    busy_q  <= 1'b1;
                    nss_q   <= 1'b0;
                    frm_q   <= bus.start_i ? 4'd0 : TRIG_FRM;
                    sr_q    <= ld_word;
                    mosi_q  <= ld_word[15];
                    if (bus.start_i) begin
                        ai_q  <= bus.adsr_ai_i;
                        di_q  <= bus.adsr_di_i;
                        s_q   <= bus.adsr_s_i;
                        ri_q  <= bus.adsr_ri_i;
                        osc_q <= bus.osc_count_i;
                        fa_q  <= bus.filter_a_i;
                        fb_q  <= bus.filter_b_i;
                    end
                end
                LEAD: if (tick) begin
                    state_q <= SHIFT;
                    sclk_q  <= 1'b1;
                end
                // high half ends on the falling edge, where the next bit is presented
                SHIFT: if (tick) begin
                    if (sclk_q) begin
                        sclk_q <= 1'b0;
                        if (bit_q != 4'd15) begin
                            mosi_q <= sr_q[14];
                            sr_q   <= sr_q << 1;
                        end
                    end else if (bit_q == 4'd15) begin
                        state_q <= TRAIL;
                        bit_q   <= '0;
                    end else begin
                        sclk_q <= 1'b1;
                        bit_q  <= bit_q + 4'd1;
                    end
                end
                TRAIL: if (tick) begin
                    state_q <= GAP;
                    nss_q   <= 1'b1;
                    mosi_q  <= 1'b0;
                end
                // bit_q[0] marks the second of the two gap half-periods
                GAP: if (tick) begin
                    bit_q <= {3'b000, ~bit_q[0]};
                    if (bit_q[0] && more) begin
                        state_q <= LEAD;
                        nss_q   <= 1'b0;
                        frm_q   <= nxt_frm;
                        sr_q    <= ld_word;
                        mosi_q  <= ld_word[15];
                    end else if (bit_q[0]) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.spi_clk_o  = sclk_q;
    assign bus.spi_mosi_o = mosi_q;
    assign bus.spi_nss_o  = nss_q;
endmodule

// File: tb/tb_spi_cfg_master.sv
// tb_spi_cfg_master: three spi_cfg_master instances (CLK_DIV 4, 2, 255) driven with random config jobs;
// an SPI decoder collects frames and protocol timing, compared against an expected frame list.
`timescale 1ns/1ps
module tb_spi_cfg_master;
`ifdef SPI_AUTO_TRIG_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  start_v = '0;
    logic [2:0]  trig_v = '0;
    logic [7:0]  ai = '0, di = '0, s = '0, ri = '0, fa = '0, fb = '0;
    logic [11:0] osc = '0;
    logic [2:0]  busy_w, done_w, sclk_w, mosi_w, nss_w;
    int          checks = 0;
    int          errors = 0;
    logic [17:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] sh[3];
    int          nb[3], hi_len[3], lat[3], done_lat[3], done_cnt[3];
    logic [2:0]  in_frm = '0, seen = '0, pb = '0, pd = '0, pc = '0, pm = '0, pn = '1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        spi_cfg_master_if b ();
        assign b.start_i     = start_v[g];
        assign b.trig_req_i  = trig_v[g];
        assign b.adsr_ai_i   = ai;
        assign b.adsr_di_i   = di;
        assign b.adsr_s_i    = s;
        assign b.adsr_ri_i   = ri;
        assign b.osc_count_i = osc;
        assign b.filter_a_i  = fa;
        assign b.filter_b_i  = fb;
        assign busy_w[g]     = b.busy_o;
        assign done_w[g]     = b.done_o;
        assign sclk_w[g]     = b.spi_clk_o;
        assign mosi_w[g]     = b.spi_mosi_o;
        assign nss_w[g]      = b.spi_nss_o;
        spi_cfg_master #(.CLK_DIV(g == 0 ? 4 : (g == 1 ? 2 : 255))) dut (.clk(clk), .rstn(rstn), .bus(b));
    end

    function automatic int cd(input int k);
        return k == 0 ? 4 : (k == 1 ? 2 : 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI slave model: decodes frames on spi_clk rising edges and checks pin timing
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rstn) begin
                if (pn[k] && !nss_w[k]) begin
                    if (seen[k]) chk($sformatf("nss_gap%0d", k), 32'(hi_len[k] >= 2 * cd(k)), 1);
                    in_frm[k] = 1'b1;
                    nb[k] = 0;
                    sh[k] = '0;
                end
                if (!pn[k] && nss_w[k] && in_frm[k]) begin
                    chk($sformatf("frame_bits%0d", k), nb[k], 16);
                    chk($sformatf("sclk_idle%0d", k), sclk_w[k], 0);
                    got_q.push_back({2'(k), sh[k]});
                    in_frm[k] = 1'b0;
                    seen[k] = 1'b1;
                    hi_len[k] = 0;
                end
                if (nss_w[k]) hi_len[k]++;
                if (!nss_w[k] && !pn[k] && mosi_w[k] != pm[k])
                    chk($sformatf("mosi_on_fall%0d", k), {pc[k], sclk_w[k]}, 2'b10);
                if (!nss_w[k] && !pc[k] && sclk_w[k]) begin
                    chk($sformatf("mosi_stable_rise%0d", k), mosi_w[k], pm[k]);
                    sh[k] = {sh[k][14:0], mosi_w[k]};
                    nb[k]++;
                end
                if (busy_w[k] && !pb[k]) lat[k] = 0;
                else lat[k]++;
                if (done_w[k]) begin
                    chk($sformatf("busy_low_at_done%0d", k), busy_w[k], 0);
                    chk($sformatf("done_width%0d", k), pd[k], 0);
                    done_lat[k] = lat[k];
                    done_cnt[k]++;
                end
            end else begin
                in_frm[k] = 1'b0;
                seen[k] = 1'b0;
            end
            pb[k] = busy_w[k];
            pd[k] = done_w[k];
            pc[k] = sclk_w[k];
            pm[k] = mosi_w[k];
            pn[k] = nss_w[k];
        end
    end

    task automatic rand_cfg();
        ai  = 8'($urandom);
        di  = 8'($urandom);
        s   = 8'($urandom);
        ri  = 8'($urandom);
        osc = 12'($urandom);
        fa  = 8'($urandom);
        fb  = 8'($urandom);
    endtask

    task automatic build_exp(input bit cfg, input bit trig);
        exp_q = {};
        if (cfg) begin
            exp_q.push_back({8'h00, ai});
            exp_q.push_back({8'h01, di});
            exp_q.push_back({8'h02, s});
            exp_q.push_back({8'h03, ri});
            exp_q.push_back({8'h04, osc[7:0]});
            exp_q.push_back({8'h05, 4'h0, osc[11:8]});
            exp_q.push_back({8'h06, fa});
            exp_q.push_back({8'h07, fb});
        end
        if (trig || (cfg && AUTO)) exp_q.push_back(16'h0801);
    endtask

    // trig_at/restart_at: cycle offset of an extra pulse after the request (-1 none, 0 with the request)
    task automatic run_job(input int k, input bit cfg, input int trig_at, input int restart_at, input string tag);
        int base;
        int want;
        logic [15:0] rx[$];
        logic [17:0] rest[$];
        build_exp(cfg, trig_at >= 0);
        want = exp_q.size() * 36 * cd(k);
        base = done_cnt[k];
        start_v[k] = cfg;
        trig_v[k] = trig_at == 0;
        @(negedge clk);
        start_v[k] = 1'b0;
        trig_v[k] = 1'b0;
        rand_cfg();
        for (int c = 1; c <= want + 20 && done_cnt[k] == base; c++) begin
            trig_v[k] = c == trig_at;
            start_v[k] = c == restart_at;
            @(negedge clk);
        end
        trig_v[k] = 1'b0;
        start_v[k] = 1'b0;
        #1;
        chk({tag, "_done"}, done_cnt[k] - base, 1);
        chk({tag, "_latency"}, done_lat[k], want);
        foreach (got_q[i]) begin
            if (got_q[i][17:16] == 2'(k)) rx.push_back(got_q[i][15:0]);
            else rest.push_back(got_q[i]);
        end
        got_q = rest;
        chk({tag, "_frames"}, rx.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < rx.size()) chk($sformatf("%s_frame%0d", tag, i), rx[i], exp_q[i]);
        repeat (4) @(negedge clk);
        chk({tag, "_idle"}, busy_w[k], 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_nss", nss_w[0], 1);
        chk("rst_sclk", sclk_w[0], 0);
        chk("rst_mosi", mosi_w[0], 0);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_done", done_w[0], 0);
        chk("rst_nss_div255", nss_w[2], 1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        ai = 8'h12; di = 8'h34; s = 8'h56; ri = 8'h78; osc = 12'hABC; fa = 8'h9A; fb = 8'hBC;
        run_job(0, 1'b1, -1, -1, "directed");
        run_job(0, 1'b0, 0, -1, "trig_only");
        for (int i = 0; i < 3; i++) begin
            rand_cfg();
            run_job(0, 1'b1, int'($urandom_range(1, 6 * 144)), int'($urandom_range(1, 7 * 144)),
                    $sformatf("mid_trig%0d", i));
        end
        rand_cfg();
        run_job(0, 1'b1, 0, -1, "coinc_trig");
        rand_cfg();
        ai = ai | 8'h80;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (69) @(negedge clk);
        chk("pre_rst_nss", nss_w[0], 0);
        chk("pre_rst_sclk", sclk_w[0], 1);
        chk("pre_rst_mosi", mosi_w[0], 1);
        #2 rstn = 1'b0;
        #1;
        chk("abort_nss", nss_w[0], 1);
        chk("abort_sclk", sclk_w[0], 0);
        chk("abort_mosi", mosi_w[0], 0);
        chk("abort_busy", busy_w[0], 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        got_q = {};
        rand_cfg();
        run_job(0, 1'b1, -1, -1, "post_rst");
        rand_cfg();
        run_job(1, 1'b1, int'($urandom_range(1, 6 * 72)), -1, "div2");
        run_job(2, 1'b0, 0, -1, "div255");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
